kuz_key_expand: RTL and testbench
=================================

KUZ_KEY_EXPAND -- requirements
Module: kuz_key_expand

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst; all state SHALL change only on the rising edge of clk.
REQ-002 Ports SHALL be exactly as follows:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request expansion; sampled only in IDLE
- key  in  256  master key; key[255:128] = K1, key[127:0] = K2
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last round-key write
- ks_data  out  128  round key to key storage
- ks_addr  out  4  key-storage write address, 0..9
- ks_we  out  1  key-storage write enable, one cycle per key

Function
REQ-003 The block SHALL implement the GOST R 34.12-2015 (Kuznechik) key schedule and produce K1..K10, writing Kn to ks_addr = n-1.
REQ-004 In IDLE, start=1 SHALL latch key into internal registers (a1 = key[255:128], a0 = key[127:0]) and move the FSM to WR0; start in any other state SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, WR0, WR1, CONST, MIX, LIN, WRA, WRB, DONE.
REQ-006 WR0 SHALL drive ks_we=1, ks_addr=0, ks_data=a1. WR1 SHALL drive ks_we=1, ks_addr=1, ks_data=a0. After WR1 the FSM SHALL go to CONST with iteration counter i=1.
REQ-007 CONST SHALL load c = Vec128(i) (i zero-extended) and apply 16 R steps, one per cycle, giving C_i = L(Vec128(i)); CONST SHALL last 16 cycles.
REQ-008 R step: for bytes a15..a0 (a15 = MSB), the result SHALL be l(a15..a0) || a15..a1.
- l = GF(2^8) sum of coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1 times a15..a0.
- Field polynomial x^8+x^7+x^6+x+1.
REQ-009 MIX SHALL take 1 cycle: t = S(a1 XOR C_i), using the standard pi S-box applied bytewise.
REQ-010 LIN SHALL take 16 cycles of R on t. At the end: a1 <= L(t) XOR a0, a0 <= a1 (old value).
REQ-011 After LIN, if i mod 8 = 0 the FSM SHALL go to WRA; otherwise it SHALL go to CONST with i incremented.
REQ-012 WRA SHALL write a1 to ks_addr = 2*(i/8). WRB SHALL write a0 to ks_addr = 2*(i/8)+1.
REQ-013 After WRB, the FSM SHALL go to CONST with i+1 if i<32, else to DONE.
REQ-014 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; busy SHALL be 0 in DONE and IDLE.
REQ-015 Timing from the start-acceptance edge SHALL be:
- 1066 cycles of WR/CONST/MIX/LIN/WRA/WRB activity (2 + 32*33 + 8);
- exactly 10 ks_we pulses, in address order 0,1,...,9;
- done in the following cycle.
REQ-016 ks_we SHALL be 0 in every state other than WR0, WR1, WRA, WRB. ks_data and ks_addr SHALL be held at 0 when ks_we=0.
REQ-017 Changes on key after acceptance SHALL NOT affect the result.
REQ-018 The counter i SHALL be 6 bits wide (range 1..32) and SHALL not wrap during a run.

Reset
REQ-019 rst=1 SHALL force the FSM to IDLE and clear busy, done, ks_we, ks_data, ks_addr, i, a1, a0 and c to 0 on the next edge, including mid-run. No further writes SHALL follow until a new start.
REQ-020 rst and start asserted in the same cycle: rst SHALL win.

Verification
REQ-021 key = 8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef, start pulse -> expected writes:
- addr0 = 8899aabbccddeeff0011223344556677
- addr1 = fedcba98765432100123456789abcdef
- addr2 = db31485315694343228d6aef8cc78c44
- addr3 = 3d4553d8e9cfec6815ebadc40a9ffd04
- addr9 = 72e9dd7416bcf45b755dbaa88e4a4043
- done 1067 cycles after start acceptance.
REQ-022 Internal check in the same run: c at the end of the first CONST = 6ea276726c487ab85d27bd10dd849401.
REQ-023 start pulsed repeatedly while busy, and key changed mid-run -> identical 10 writes and a single done pulse.
REQ-024 rst asserted during LIN of iteration 12 -> next cycle busy=0, ks_we=0; no writes for 200 cycles. A new start after that -> full, correct 10-key sequence.
REQ-025 Connected to the team key_storage (we=ks_we, wr_addr=ks_addr, data=ks_data), after done, reading rd_addr 0..9 -> K1..K10. Addresses 10..15 remain 0.
REQ-026 rst=1 and start=1 in the same cycle -> block stays IDLE, busy=0, no ks_we.

Source files
------------

// File: rtl/kuz_key_expand.sv
// kuz_key_expand: Kuznechik (GOST R 34.12-2015) key schedule engine.
// Expands a 256-bit master key into ten 128-bit round keys K1..K10 and
// writes Kn to key storage at address n-1, one write per cycle of ks_we.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-high reset
//   start    request expansion, only sampled while idle
//   key      master key: key[255:128] = K1, key[127:0] = K2
//   busy     high while an expansion is in progress (not in DONE/IDLE)
//   done     one-cycle pulse after the last round-key write
//   ks_data  round key to key storage (0 when ks_we is low)
//   ks_addr  key-storage write address 0..9 (0 when ks_we is low)
//   ks_we    key-storage write enable
//
// Handshake: start is a level request taken only in IDLE; once taken the
// key is latched, busy rises on the next cycle and later requests are
// ignored until done has pulsed and the block is back in IDLE.
//
// Internal state (state, i, c, a1, a0) is kept in plainly named registers
// so checkers can observe it hierarchically.
module kuz_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ks_data,
  output logic [3:0]   ks_addr,
  output logic         ks_we
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WR0   = 4'd1;
  localparam logic [3:0] S_WR1   = 4'd2;
  localparam logic [3:0] S_CONST = 4'd3;
  localparam logic [3:0] S_MIX   = 4'd4;
  localparam logic [3:0] S_LIN   = 4'd5;
  localparam logic [3:0] S_WRA   = 4'd6;
  localparam logic [3:0] S_WRB   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [7:0] PI [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  // Coefficients of l, index 0 multiplies the most significant byte a15.
  localparam logic [7:0] L_COEF [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1 (reduction byte 0xC3).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  // One R step: new top byte is l(a15..a0), the rest shifts down a byte.
  function automatic logic [127:0] r_step(input logic [127:0] a);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(a[127-8*k -: 8], L_COEF[k]);
    return {acc, a[127:8]};
  endfunction

  logic [3:0]   state;
  logic [3:0]   step;
  logic [5:0]   i;
  logic [5:0]   i_next;
  logic [127:0] a1, a0, c, t;
  logic [127:0] r_in, r_out, mix_in, s_out;

  // One R unit is shared: CONST steps the constant, LIN steps t.
  always_comb begin
    r_in   = (state == S_LIN) ? t : c;
    r_out  = r_step(r_in);
    i_next = i + 6'd1;
    mix_in = a1 ^ c;
    s_out  = '0;
    for (int b = 0; b < 16; b++) s_out[8*b +: 8] = PI[mix_in[8*b +: 8]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= 4'd0;
      i     <= 6'd0;
      a1    <= '0;
      a0    <= '0;
      c     <= '0;
      t     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a1    <= key[255:128];
            a0    <= key[127:0];
            state <= S_WR0;
          end
        end
        S_WR0: state <= S_WR1;
        S_WR1: begin
          i     <= 6'd1;
          c     <= 128'd1;
          step  <= 4'd0;
          state <= S_CONST;
        end
        S_CONST: begin
          c    <= r_out;
          step <= step + 4'd1;
          if (step == 4'd15) state <= S_MIX;
        end
        S_MIX: begin
          t     <= s_out;
          state <= S_LIN;
        end
        S_LIN: begin
          t    <= r_out;
          step <= step + 4'd1;
          if (step == 4'd15) begin
            // Feistel swap: r_out is L(t) on this last step.
            a1 <= r_out ^ a0;
            a0 <= a1;
            if (i[2:0] == 3'd0) begin
              state <= S_WRA;
            end else begin
              i     <= i_next;
              c     <= {122'd0, i_next};
              state <= S_CONST;
            end
          end
        end
        S_WRA: state <= S_WRB;
        S_WRB: begin
          if (i < 6'd32) begin
            i     <= i_next;
            c     <= {122'd0, i_next};
            state <= S_CONST;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register; the write bus is zero unless writing.
  always_comb begin
    busy    = (state != S_IDLE) && (state != S_DONE);
    done    = (state == S_DONE);
    ks_we   = 1'b0;
    ks_addr = 4'd0;
    ks_data = '0;
    case (state)
      S_WR0: begin ks_we = 1'b1; ks_addr = 4'd0;            ks_data = a1; end
      S_WR1: begin ks_we = 1'b1; ks_addr = 4'd1;            ks_data = a0; end
      S_WRA: begin ks_we = 1'b1; ks_addr = {i[5:3], 1'b0};  ks_data = a1; end
      S_WRB: begin ks_we = 1'b1; ks_addr = {i[5:3], 1'b1};  ks_data = a0; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kuz_key_expand.sv
// tb_kuz_key_expand: directed bench for kuz_key_expand using the published
// Kuznechik key-schedule example vector.
module tb_kuz_key_expand;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_MIX  = 4'd4;
  localparam logic [3:0] S_LIN  = 4'd5;

  localparam logic [255:0] KEY_A =
    256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [127:0] C1 = 128'h6ea276726c487ab85d27bd10dd849401;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] data;
  } wr_vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic [127:0] ks_data;
  logic [3:0]   ks_addr;
  logic         ks_we;

  wr_vec_t      vec [10];
  logic [131:0] exp_q [$];
  logic [131:0] mon_e;
  logic [127:0] mem [16];
  int           n_checks = 0;
  int           n_fail = 0;
  int           wr_count = 0;
  int           done_count = 0;
  bit           c1_checked = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  kuz_key_expand dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .ks_data (ks_data),
    .ks_addr (ks_addr),
    .ks_we   (ks_we)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard + key-storage model, sampled on the falling edge
  always @(negedge clk) begin
    if (ks_we) begin
      wr_count++;
      mem[ks_addr] = ks_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", ks_addr, ks_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("ks_write", {124'd0, ks_addr, ks_data}, {124'd0, mon_e});
      end
    end else begin
      check("bus_zero_when_idle", {124'd0, ks_addr, ks_data}, 256'd0);
    end
    if (done) done_count++;
    if (!c1_checked && dut.state == S_MIX && dut.i == 6'd1) begin
      c1_checked = 1'b1;
      check("c_after_first_const", {128'd0, dut.c}, {128'd0, C1});
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_expected();
    for (int k = 0; k < 10; k++) exp_q.push_back({vec[k].addr, vec[k].data});
  endtask

  task automatic run_expand(input logic [255:0] k, input bit noisy);
    int cyc;
    int wr0;
    int dn0;
    wr0 = wr_count;
    dn0 = done_count;
    for (int m = 0; m < 16; m++) mem[m] = '0;
    load_expected();
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check("busy_after_accept", {255'd0, busy}, 256'd1);
    while (!done && cyc < 1200) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        key   = {8{$urandom()}};
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    key   = k;
    check("done_cycle", 256'(cyc), 256'd1067);
    @(negedge clk);
    check("done_single_cycle", {255'd0, done}, 256'd0);
    check("busy_low_after_done", {255'd0, busy}, 256'd0);
    check("write_count", 256'(wr_count - wr0), 256'd10);
    check("done_count", 256'(done_count - dn0), 256'd1);
    check("exp_q_drained", 256'(exp_q.size()), 256'd0);
    for (int m = 0; m < 10; m++) check("storage_key", {128'd0, mem[m]}, {128'd0, vec[m].data});
    for (int m = 10; m < 16; m++) check("storage_unused", {128'd0, mem[m]}, 256'd0);
  endtask

  initial begin
    int cyc;
    int wr0;
    bit found;

    vec[0] = '{4'd0, 128'h8899aabbccddeeff0011223344556677};
    vec[1] = '{4'd1, 128'hfedcba98765432100123456789abcdef};
    vec[2] = '{4'd2, 128'hdb31485315694343228d6aef8cc78c44};
    vec[3] = '{4'd3, 128'h3d4553d8e9cfec6815ebadc40a9ffd04};
    vec[4] = '{4'd4, 128'h57646468c44a5e28d3e59246f429f1ac};
    vec[5] = '{4'd5, 128'hbd079435165c6432b532e82834da581b};
    vec[6] = '{4'd6, 128'h51e640757e8745de705727265a0098b1};
    vec[7] = '{4'd7, 128'h5a7925017b9fdd3ed72a91a22286f984};
    vec[8] = '{4'd8, 128'hbb44e25378c73123a5f32f73cdb6e517};
    vec[9] = '{4'd9, 128'h72e9dd7416bcf45b755dbaa88e4a4043};

    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    tick(3);
    check("reset_busy", {255'd0, busy}, 256'd0);
    check("reset_done", {255'd0, done}, 256'd0);
    check("reset_we", {255'd0, ks_we}, 256'd0);
    check("reset_state", {252'd0, dut.state}, {252'd0, S_IDLE});
    rst = 1'b0;
    tick(2);

    // clean run with the reference key
    run_expand(KEY_A, 1'b0);
    check("c1_observed", {255'd0, c1_checked}, 256'd1);

    // start pulses and key changes while busy
    run_expand(KEY_A, 1'b1);

    // reset during LIN of iteration 12
    wr0 = wr_count;
    load_expected();
    @(negedge clk);
    key   = KEY_A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = '0;
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 2000) begin
      if (dut.state == S_LIN && dut.i == 6'd12) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("reached_lin_i12", {255'd0, found}, 256'd1);
    check("writes_before_abort", 256'(wr_count - wr0), 256'd4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {255'd0, busy}, 256'd0);
    check("abort_we", {255'd0, ks_we}, 256'd0);
    check("abort_state", {252'd0, dut.state}, {252'd0, S_IDLE});
    rst = 1'b0;
    exp_q.delete();
    wr0 = wr_count;
    tick(200);
    check("no_writes_after_abort", 256'(wr_count - wr0), 256'd0);
    run_expand(KEY_A, 1'b0);

    // rst and start together
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    key   = KEY_A;
    @(negedge clk);
    check("rst_start_busy", {255'd0, busy}, 256'd0);
    check("rst_start_we", {255'd0, ks_we}, 256'd0);
    rst   = 1'b0;
    start = 1'b0;
    wr0   = wr_count;
    tick(5);
    check("rst_start_no_writes", 256'(wr_count - wr0), 256'd0);
    check("rst_start_state", {252'd0, dut.state}, {252'd0, S_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
